// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel-side and output-side handshake bundle for rr_arb_mux
interface rr_arb_mux_if #(
  parameter int N = 32,
  parameter int M = 16,
  localparam int SEL_W = $clog2(M)
);
  logic [M-1:0]     in_valid;
  logic [M-1:0]     in_ready;
  logic [M*N-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - M:1 channel mux with fixed-select or round-robin grant into one output register
module rr_arb_mux #(
  parameter int N = 32,
  parameter int M = 16,
  localparam int SEL_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  rr_arb_mux_if.slave      bus,
  input  logic             mode,
  input  logic [SEL_W-1:0] s
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] g;
  logic [N-1:0]     g_data;
  logic             grant;
  logic             load_en;
  logic [M-1:0]     in_ready_c;

  assign load_en = !bus.out_valid || bus.out_ready;

  // Round-robin scans rr_ptr..M-1 first; if nothing there, any valid channel is below rr_ptr.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    if (!mode) begin
      for (int i = 0; i < M; i++) begin
        if (s == SEL_W'(i) && bus.in_valid[i]) begin
          grant = 1'b1;
          g     = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        if (!grant && SEL_W'(i) >= rr_ptr && bus.in_valid[i]) begin
          grant = 1'b1;
          g     = SEL_W'(i);
        end
      end
      for (int i = 0; i < M; i++) begin
        if (!grant && bus.in_valid[i]) begin
          grant = 1'b1;
          g     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    g_data     = '0;
    in_ready_c = '0;
    for (int i = 0; i < M; i++) begin
      if (g == SEL_W'(i)) begin
        g_data        = bus.in_data[i*N +: N];
        in_ready_c[i] = !rst && load_en && grant;
      end
    end
  end

  assign bus.in_ready = in_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      rr_ptr        <= '0;
    end else if (load_en) begin
      if (grant) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= g_data;
        bus.out_sel   <= g;
        if (mode) begin
          rr_ptr <= (g == SEL_W'(M-1)) ? '0 : g + 1'b1;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed scoreboard bench for rr_arb_mux with M=16 and M=5 instances
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst;
  logic mode16, mode5;
  logic [3:0] s16;
  logic [2:0] s5;

  int n_checks = 0;
  int n_fail   = 0;

  int          q16_sel[$];
  logic [31:0] q16_data[$];
  int          q5_sel[$];
  logic [31:0] q5_data[$];

  rr_arb_mux_if #(.N(32), .M(16)) b16();
  rr_arb_mux_if #(.N(32), .M(5))  b5();

  rr_arb_mux #(.N(32), .M(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave), .mode(mode16), .s(s16));
  rr_arb_mux #(.N(32), .M(5))  u5  (.clk(clk), .rst(rst), .bus(b5.slave),  .mode(mode5),  .s(s5));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push16(input int ch);
    q16_sel.push_back(ch);
    q16_data.push_back(32'hA5A5_0000 | 32'(ch));
  endtask

  task automatic push5(input int ch);
    q5_sel.push_back(ch);
    q5_data.push_back(32'hA5A5_0000 | 32'(ch));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: every accepted output beat must match the head of its queue
  always @(negedge clk) begin
    if (!rst && b16.out_valid && b16.out_ready) begin
      check("u16_expected_beat", 64'(q16_sel.size() != 0), 64'd1);
      if (q16_sel.size() != 0) begin
        int es;
        logic [31:0] ed;
        es = q16_sel.pop_front();
        ed = q16_data.pop_front();
        check("u16_out_sel", 64'(b16.out_sel), 64'(es));
        check("u16_out_data", 64'(b16.out_data), 64'(ed));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b5.out_valid && b5.out_ready) begin
      check("u5_expected_beat", 64'(q5_sel.size() != 0), 64'd1);
      if (q5_sel.size() != 0) begin
        int es;
        logic [31:0] ed;
        es = q5_sel.pop_front();
        ed = q5_data.pop_front();
        check("u5_out_sel", 64'(b5.out_sel), 64'(es));
        check("u5_out_data", 64'(b5.out_data), 64'(ed));
      end
    end
  end

  initial begin
    rst = 1'b1;
    mode16 = 1'b1; s16 = '0;
    mode5  = 1'b1; s5  = '0;
    b16.in_valid = '1;
    b5.in_valid  = '1;
    b16.out_ready = 1'b1;
    b5.out_ready  = 1'b1;
    for (int i = 0; i < 16; i++) b16.in_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    for (int i = 0; i < 5; i++)  b5.in_data[i*32 +: 32]  = 32'hA5A5_0000 | 32'(i);

    // reset with every channel requesting
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready16", 64'(b16.in_ready), 64'd0);
      check("rst_in_ready5", 64'(b5.in_ready), 64'd0);
      cyc();
    end
    check("rst_out_valid16", 64'(b16.out_valid), 64'd0);
    check("rst_out_data16", 64'(b16.out_data), 64'd0);
    check("rst_out_sel16", 64'(b16.out_sel), 64'd0);
    check("rst_out_valid5", 64'(b5.out_valid), 64'd0);
    rst = 1'b0;
    b5.in_valid = '0;

    // round-robin over all 16, then wrap back to 0
    @(negedge clk);
    check("rr_first_grant", 64'(b16.in_ready), 64'h0001);
    for (int i = 0; i < 16; i++) push16(i);
    push16(0);
    repeat (17) cyc();
    b16.in_valid = '0;
    repeat (2) cyc();

    // two requesters alternate, rr_ptr is at 1
    b16.in_valid = 16'h1008;
    push16(3); push16(12); push16(3); push16(12);
    repeat (4) cyc();
    b16.in_valid = '0;
    repeat (2) cyc();

    // backpressure with ch7 held, rr_ptr is at 13
    b16.out_ready = 1'b0;
    b16.in_valid  = 16'h0080;
    push16(7);
    cyc();
    b16.in_valid = 16'h0180;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(b16.in_ready), 64'd0);
      check("stall_out_valid", 64'(b16.out_valid), 64'd1);
      check("stall_out_sel", 64'(b16.out_sel), 64'd7);
      check("stall_out_data", 64'(b16.out_data), 64'hA5A5_0007);
      cyc();
    end
    b16.out_ready = 1'b1;
    push16(8);
    @(negedge clk);
    check("pop_push_in_ready", 64'(b16.in_ready), 64'h0100);
    cyc();
    b16.in_valid = '0;
    repeat (2) cyc();

    // fixed select s=5, rr_ptr is at 9
    mode16 = 1'b0;
    s16 = 4'd5;
    b16.in_valid = '1;
    repeat (3) begin
      push16(5);
      @(negedge clk);
      check("fixed_in_ready", 64'(b16.in_ready), 64'h0020);
      cyc();
    end
    b16.in_valid = '0;
    repeat (2) cyc();

    // rr_ptr untouched by fixed mode
    mode16 = 1'b1;
    b16.in_valid = '1;
    @(negedge clk);
    check("rr_ptr_kept_in_ready", 64'(b16.in_ready), 64'h0200);
    push16(9);
    cyc();
    b16.in_valid = '0;
    repeat (2) cyc();

    // fixed select on a channel that stops requesting
    mode16 = 1'b0;
    s16 = 4'd3;
    b16.in_valid = '1;
    push16(3);
    cyc();
    b16.in_valid = 16'hFFF7;
    @(negedge clk);
    check("s3_invalid_in_ready", 64'(b16.in_ready), 64'd0);
    cyc();
    @(negedge clk);
    check("s3_invalid_out_valid", 64'(b16.out_valid), 64'd0);
    cyc();
    b16.in_valid = '0;

    // M=5: out-of-range select never grants
    mode5 = 1'b0;
    s5 = 3'd7;
    b5.in_valid = 5'h1F;
    repeat (3) begin
      @(negedge clk);
      check("m5_oob_in_ready", 64'(b5.in_ready), 64'd0);
      check("m5_oob_out_valid", 64'(b5.out_valid), 64'd0);
      cyc();
    end

    // M=5: round-robin wraps 4 -> 0
    mode5 = 1'b1;
    push5(0); push5(1); push5(2); push5(3); push5(4); push5(0);
    repeat (6) cyc();
    b5.in_valid = '0;
    repeat (2) cyc();

    // reset during a stall discards the held beat and rr_ptr
    mode16 = 1'b1;
    b16.out_ready = 1'b0;
    b16.in_valid = 16'h0004;
    cyc();
    b16.in_valid = '0;
    @(negedge clk);
    check("pre_rst_out_valid", 64'(b16.out_valid), 64'd1);
    check("pre_rst_out_sel", 64'(b16.out_sel), 64'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b16.out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(b16.out_valid), 64'd0);
    cyc();
    b16.in_valid = '1;
    @(negedge clk);
    check("mid_rst_rr_ptr", 64'(b16.in_ready), 64'h0001);
    push16(0);
    cyc();
    b16.in_valid = '0;
    repeat (3) cyc();

    check("q16_drained", 64'(q16_sel.size()), 64'd0);
    check("q5_drained", 64'(q5_sel.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
